pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RV32I pipeline (F, D, E, M, W).
- Each cycle it decides whether every pipeline register advances, holds, or loads a bubble (NOP `32'h00000013`).
- It covers load-use hazards, taken branches/jumps resolved in E, instruction-fetch wait and data-memory wait.
- It drives the stall/flush inputs of the F/PC, D, E and M stage registers.

---
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: D/E operand info, memory handshakes and stage stall/flush strobes.
// Perf counter signals exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic        d_use_rs1;
  logic        d_use_rs2;
  logic [4:0]  e_rd;
  logic        e_is_load;
  logic        e_jb;
  logic        imem_ready;
  logic        dmem_req;
  logic        dmem_ack;
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        stall_m;
  logic        flush_d;
  logic        flush_e;
  logic        dmem_err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  modport master (
    output d_rs1, d_rs2, d_use_rs1, d_use_rs2, e_rd, e_is_load, e_jb,
           imem_ready, dmem_req, dmem_ack,
`ifdef PIPE_HAZARD_PERF_EN
    input  perf_stall_cnt, perf_flush_cnt,
`endif
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, dmem_err
  );

  modport slave (
    input  d_rs1, d_rs2, d_use_rs1, d_use_rs2, e_rd, e_is_load, e_jb,
           imem_ready, dmem_req, dmem_ack,
`ifdef PIPE_HAZARD_PERF_EN
    output perf_stall_cnt, perf_flush_cnt,
`endif
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, dmem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline (load-use, E-stage jumps, fetch and data-memory waits).
// Optional stall/flush event counters are enabled with the macro PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam bit             TO_EN   = (DMEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(DMEM_TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             lu;
  logic             timeout;
  logic             freeze;

  always_comb begin
    lu      = hz.e_is_load && (hz.e_rd != 5'd0) &&
              ((hz.d_use_rs1 && (hz.d_rs1 == hz.e_rd)) ||
               (hz.d_use_rs2 && (hz.d_rs2 == hz.e_rd)));
    timeout = (state_q == MEM_WAIT) && TO_EN && (wcnt_q == TO_LAST);
    freeze  = ((state_q == RUN) && hz.dmem_req && !hz.dmem_ack) ||
              ((state_q == MEM_WAIT) && !hz.dmem_ack && !timeout);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ack) begin
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ack || timeout) state_d = RUN;
        else                        wcnt_d  = wcnt_q + 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Priority: memory freeze > E-stage redirect > load-use bubble > fetch bubble.
  always_comb begin
    hz.stall_f  = 1'b0;
    hz.stall_d  = 1'b0;
    hz.stall_e  = 1'b0;
    hz.stall_m  = 1'b0;
    hz.flush_d  = 1'b0;
    hz.flush_e  = 1'b0;
    hz.dmem_err = 1'b0;
    if (!rst) begin
      hz.dmem_err = timeout;
      if (freeze) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.stall_e = 1'b1;
        hz.stall_m = 1'b1;
      end else if (hz.e_jb) begin
        hz.flush_d = 1'b1;
        hz.flush_e = 1'b1;
      end else if (lu) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.flush_e = 1'b1;
      end else if (!hz.imem_ready) begin
        hz.stall_f = 1'b1;
        hz.flush_d = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (hz.stall_f)               perf_stall_q <= perf_stall_q + 32'd1;
      if (hz.flush_d || hz.flush_e) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed hazard scenarios with literal expectations plus a randomized run
// checked every cycle against a wait-length based behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.DMEM_TIMEOUT(T), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: number of consecutive cycles the current data access has already been frozen.
  int         wl = 0;
  logic       m_freeze;
  logic [6:0] exp_v;
  logic [6:0] act_v;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic ld, input logic jb, input logic imem,
                        input logic req, input logic ack);
    hz.d_rs1 = rs1;  hz.d_rs2 = rs2;  hz.d_use_rs1 = u1;  hz.d_use_rs2 = u2;
    hz.e_rd = rd;    hz.e_is_load = ld;  hz.e_jb = jb;
    hz.imem_ready = imem;  hz.dmem_req = req;  hz.dmem_ack = ack;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Expected outputs {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, dmem_err}.
  function automatic void model_eval();
    logic err;
    logic hit;
    m_freeze = 1'b0;
    err      = 1'b0;
    if (wl == 0)                  m_freeze = hz.dmem_req && !hz.dmem_ack;
    else if (T != 0 && wl == T)   err = 1'b1;
    else                          m_freeze = !hz.dmem_ack;
    hit = 1'b0;
    if (hz.e_is_load && hz.e_rd != 0) begin
      if (hz.d_use_rs1 && hz.d_rs1 == hz.e_rd) hit = 1'b1;
      if (hz.d_use_rs2 && hz.d_rs2 == hz.e_rd) hit = 1'b1;
    end
    if (rst)                 exp_v = 7'b0000000;
    else if (m_freeze)       exp_v = 7'b1111000;
    else if (hz.e_jb)        exp_v = 7'b0000110;
    else if (hit)            exp_v = 7'b1100010;
    else if (!hz.imem_ready) exp_v = 7'b1000100;
    else                     exp_v = 7'b0000000;
    if (!rst) exp_v[0] = err;
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      wl = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      wl = m_freeze ? wl + 1 : 0;
      if (exp_v[6])            m_stall = m_stall + 1;
      if (exp_v[2] || exp_v[1]) m_flush = m_flush + 1;
    end
  endfunction

  task automatic cyc(input string name, input int want);
    #2;
    act_v = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e, hz.dmem_err};
    model_eval();
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s model: got %b expected %b (t=%0t)", name, act_v, exp_v, $time);
    end
    if (want >= 0) begin
      n_tests++;
      if (act_v !== want[6:0]) begin
        n_fail++;
        $display("FAIL %s literal: got %b expected %b", name, act_v, want[6:0]);
      end
    end
`ifdef PIPE_HAZARD_PERF_EN
    n_tests++;
    if (hz.perf_stall_cnt !== m_stall || hz.perf_flush_cnt !== m_flush) begin
      n_fail++;
      $display("FAIL %s perf: got %0d/%0d expected %0d/%0d", name,
               hz.perf_stall_cnt, hz.perf_flush_cnt, m_stall, m_flush);
    end
`endif
    model_step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_in(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    cyc("reset0", 0);
    cyc("reset1", 0);
    rst = 1'b0;
    idle();
    cyc("idle", 0);

    // Load-use, then x0 destination.
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("lu", 7'b1100010);
    idle();
    cyc("lu_after", 0);
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("lu_x0", 0);
    set_in(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("lu_rs2", 7'b1100010);

    // Branch together with a load-use match.
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("jb_lu", 7'b0000110);

    // Data-memory wait acked after 3 frozen cycles.
    idle(); hz.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("dm_wait", 7'b1111000);
    hz.dmem_ack = 1'b1;
    cyc("dm_ack", 0);
    idle();
    cyc("dm_idle", 0);

    // Timeout: 4 frozen cycles then a one-cycle error pulse with release.
    idle(); hz.dmem_req = 1'b1;
    for (int i = 0; i < T; i++) cyc("to_wait", 7'b1111000);
    cyc("to_err", 7'b0000001);
    idle();
    cyc("to_run", 0);

    // Fetch wait for 2 cycles.
    idle(); hz.imem_ready = 1'b0;
    cyc("if_wait0", 7'b1000100);
    cyc("if_wait1", 7'b1000100);
    idle();
    cyc("if_done", 0);

    // Jump during a freeze is deferred to the release cycle.
    idle(); hz.dmem_req = 1'b1; hz.e_jb = 1'b1;
    cyc("jb_frz0", 7'b1111000);
    cyc("jb_frz1", 7'b1111000);
    hz.dmem_ack = 1'b1;
    cyc("jb_rel", 7'b0000110);

    // Load-use during a freeze is re-evaluated on release.
    set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("lu_frz", 7'b1111000);
    hz.dmem_ack = 1'b1;
    cyc("lu_rel", 7'b1100010);
    idle();
    cyc("lu_rel_idle", 0);

    // Asynchronous reset in the middle of a wait.
    idle(); hz.dmem_req = 1'b1;
    cyc("rw_frz0", 7'b1111000);
    cyc("rw_frz1", 7'b1111000);
    cyc("rw_frz2", 7'b1111000);
    rst = 1'b1;
    cyc("rw_rst0", 0);
    cyc("rw_rst1", 0);
    rst = 1'b0;
    idle();
    cyc("rw_post", 0);
`ifdef PIPE_HAZARD_PERF_EN
    n_tests++;
    if (hz.perf_stall_cnt !== 32'd0 || hz.perf_flush_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_after_rst: got %0d/%0d expected 0/0", hz.perf_stall_cnt, hz.perf_flush_cnt);
    end
`endif

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3));
      rst = ($urandom_range(0, 199) == 0);
      cyc("rand", -1);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
